// File: rtl/mask_decompressor.sv
// Expands a compacted element stream back into a dense LANES-wide vector,
// placing successive elements into the lanes selected by a mask.
module mask_decompressor #(
   parameter int LANES = 32,
   parameter int DW    = 8,
   parameter int BEAT  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [LANES-1:0]      mask,
   input  logic                  mask_valid,
   output logic                  mask_ready,
   input  logic [BEAT*DW-1:0]    din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [LANES*DW-1:0]   dense,
   output logic                  dense_valid,
   input  logic                  dense_ready
);

   localparam int CW = $clog2(LANES + BEAT) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t              state_r, next_state_s;
   logic [CW-1:0]       cnt_r;
   logic [CW-1:0]       k_r;
   logic [LANES-1:0]    mask_r;
   logic [LANES*DW-1:0] dense_r;
   logic                mask_ready_r, din_ready_r, dense_valid_r;
   logic [CW-1:0]       rank_s [LANES];
   logic [CW-1:0]       rank_acc_s;
   logic [CW-1:0]       k_in_s;
   logic                mask_fire_s, din_fire_s, dense_fire_s;

   function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
      logic [CW-1:0] c;
      c = {CW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   assign mask_fire_s  = mask_valid & mask_ready_r;
   assign din_fire_s   = din_valid & din_ready_r;
   assign dense_fire_s = dense_valid_r & dense_ready;
   assign k_in_s       = popcount(mask);

   // Exclusive prefix count of the registered mask: rank of each lane in the stream.
   always_comb begin
      rank_acc_s = {CW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         rank_s[i]  = rank_acc_s;
         rank_acc_s = rank_acc_s + CW'(mask_r[i]);
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (mask_fire_s) begin
               next_state_s = (k_in_s == {CW{1'b0}}) ? OUT : LOAD;
            end else begin
               next_state_s = IDLE;
            end
         end
         LOAD: begin
            if (din_fire_s && ((cnt_r + CW'(BEAT)) >= k_r)) begin
               next_state_s = OUT;
            end else begin
               next_state_s = LOAD;
            end
         end
         OUT: begin
            if (dense_fire_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = OUT;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, counters and handshake outputs; outputs are decoded from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= IDLE;
         cnt_r         <= {CW{1'b0}};
         k_r           <= {CW{1'b0}};
         mask_r        <= {LANES{1'b0}};
         mask_ready_r  <= 1'b0;
         din_ready_r   <= 1'b0;
         dense_valid_r <= 1'b0;
      end else begin
         state_r       <= next_state_s;
         mask_ready_r  <= (next_state_s == IDLE);
         din_ready_r   <= (next_state_s == LOAD);
         dense_valid_r <= (next_state_s == OUT);
         if (mask_fire_s) begin
            mask_r <= mask;
            k_r    <= k_in_s;
            cnt_r  <= {CW{1'b0}};
         end else if (din_fire_s) begin
            cnt_r  <= cnt_r + CW'(BEAT);
         end
      end
   end

   // Lane capture: a masked lane whose rank falls inside the current beat takes that element.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dense_r <= {(LANES*DW){1'b0}};
      end else if (mask_fire_s) begin
         dense_r <= {(LANES*DW){1'b0}};
      end else if (din_fire_s) begin
         for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < BEAT; k++) begin
               if (mask_r[i] && (rank_s[i] == (cnt_r + CW'(k)))) begin
                  dense_r[i*DW +: DW] <= din[k*DW +: DW];
               end
            end
         end
      end
   end

   assign mask_ready  = mask_ready_r;
   assign din_ready   = din_ready_r;
   assign dense_valid = dense_valid_r;
   assign dense       = dense_r;

endmodule

// File: doc/mask_decompressor.md
MASK_DECOMPRESSOR -- requirements
Module: mask_decompressor

Interface
REQ-001 SHALL expose parameters: LANES, 32, dense vector lanes; DW, 8, bits per element; BEAT, 4, compacted elements per input beat.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 mask  input  LANES  bit i set = lane i holds a compacted element.
REQ-006 mask_valid  input  1  mask offered.
REQ-007 mask_ready  output  1  mask accepted when mask_valid and mask_ready are both high.
REQ-008 din  input  BEAT*DW  compacted elements; element k at din[k*DW +: DW], k=0 is the oldest.
REQ-009 din_valid  input  1  beat offered.
REQ-010 din_ready  output  1  beat accepted when din_valid and din_ready are both high.
REQ-011 dense  output  LANES*DW  reconstructed vector; lane i at dense[i*DW +: DW].
REQ-012 dense_valid  output  1  dense holds a complete vector.
REQ-013 dense_ready  input  1  consumer takes the vector when dense_valid and dense_ready are both high.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD and OUT.
REQ-015 IDLE: mask_ready=1, din_ready=0, dense_valid=0.
REQ-016 On mask handshake, SHALL register mask, clear dense to 0, clear fill count cnt to 0, and latch K = popcount(mask).
REQ-017 On mask handshake with K=0, SHALL go IDLE->OUT; with K>0, IDLE->LOAD.
REQ-018 LOAD: din_ready=1, mask_ready=0, dense_valid=0.
REQ-019 Per lane i, rank r_i SHALL be the count of set mask bits at indices below i (exclusive prefix sum).
REQ-020 On each beat handshake, every masked lane i with cnt <= r_i < cnt+BEAT SHALL capture din element (r_i - cnt); all other lanes SHALL hold their value.
REQ-021 Each beat handshake SHALL add BEAT to cnt, with cnt at least clog2(LANES+BEAT)+1 bits wide and no wrap.
REQ-022 When a beat makes cnt+BEAT >= K, SHALL go LOAD->OUT on that edge.
REQ-023 Elements beyond K in the final partial beat SHALL be ignored.
REQ-024 Unmasked lanes SHALL read 0 in OUT.
REQ-025 Latency: dense_valid SHALL rise on the clock edge that accepts the last beat, so it is visible the following cycle.
REQ-026 For K=0, dense_valid SHALL rise on the edge that accepts the mask.
REQ-027 OUT: dense_valid=1, din_ready=0, mask_ready=0.
REQ-028 In OUT, dense SHALL stay stable while dense_ready=0.
REQ-029 On the dense handshake, SHALL go OUT->IDLE.
REQ-030 A new mask SHALL be accepted no earlier than the cycle after the dense handshake (one-cycle bubble).
REQ-031 din_valid outside LOAD and mask_valid outside IDLE SHALL be ignored with no state change.
REQ-032 Full mask (K=LANES) SHALL take exactly LANES/BEAT beats.

Reset
REQ-033 While reset_n=0, SHALL force state=IDLE, cnt=0, K=0, mask register=0, dense=0, dense_valid=0, din_ready=0 and mask_ready=0, asynchronously.
REQ-034 After reset release, mask_ready SHALL be 1 from the first clock edge.
REQ-035 Reset asserted in LOAD or OUT SHALL discard the partial vector; no dense handshake SHALL follow for that vector.

Verification
REQ-036 mask=32'h0808_2013 (lanes 0,1,4,13,19,27 set), beat0 din=32'h44332211, beat1 din=32'hAABB6655 -> dense lanes 0,1,4,13,19,27 = 11,22,33,44,55,66; all other lanes 0; dense_valid on the cycle after beat1; AA and BB discarded.
REQ-037 mask=32'hFFFF_FFFF, 8 beats carrying elements 0x00..0x1F in order -> lane i = i; din_ready low after beat 8.
REQ-038 mask=0 -> dense_valid the cycle after the mask handshake, dense all zero, din_ready never high.
REQ-039 Same stimulus as REQ-036 with dense_ready held low for 5 cycles -> dense and dense_valid stable for those 5 cycles, mask_ready=0 throughout, IDLE reached one cycle after dense_ready rises.
REQ-040 din_valid toggling 1,0,1 during LOAD -> only handshaked beats advance cnt; result identical to REQ-036.
REQ-041 reset_n pulsed low after beat0 of REQ-036 -> all outputs at reset values immediately; a following mask=32'h1 with one beat 0x77 yields lane0=0x77 and all other lanes 0.
